// File: rtl/fifo_input_control.sv
// Write-side control for the 32 x 8 FIFO: qualifies producer writes, drives the
// storage write port and tracks occupancy from read acknowledges.
module fifo_input_control #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_ack,
  output logic                  write_en_o,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic [DATA_WIDTH-1:0] data_in_f,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  zero_reject,
  output logic [ADDR_WIDTH:0]   count_o
);

  // state  | meaning
  // EMPTY  | occupancy == 0
  // ACTIVE | 0 < occupancy < DEPTH
  // FULL   | occupancy == DEPTH

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CW-1:0]         occ_nxt;
  logic                  data_nz;
  logic                  accept;
  logic                  refuse;
  logic                  zero_drop;
  logic                  dec;

  assign data_nz   = |data_in;
  // A read_ack in the same cycle frees the slot, so a full FIFO may still accept.
  assign accept    = write_en && data_nz && ((state != FULL) || read_ack);
  assign refuse    = write_en && data_nz && (state == FULL) && !read_ack;
  assign zero_drop = write_en && !data_nz;
  assign dec       = read_ack && (state != EMPTY);

  always_comb begin
    occ_nxt = count_o;
    if (accept && !dec)
      occ_nxt = count_o + CW'(1);
    else if (dec && !accept)
      occ_nxt = count_o - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      write_en_o  <= 1'b0;
      ptr         <= '0;
      data_in_f   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      zero_reject <= 1'b0;
      count_o     <= '0;
    end else begin
      write_en_o  <= accept;
      zero_reject <= zero_drop;
      if (accept) begin
        ptr       <= wr_ptr;
        data_in_f <= data_in;
        wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
        overflow  <= 1'b0;
      end else if (refuse) begin
        overflow  <= 1'b1;
      end
      count_o     <= occ_nxt;
      full        <= (occ_nxt == DEPTH_C);
      almost_full <= (occ_nxt >= AFULL_C);
      if (occ_nxt == '0)
        state <= EMPTY;
      else if (occ_nxt == DEPTH_C)
        state <= FULL;
      else
        state <= ACTIVE;
    end
  end

endmodule

// File: tb/tb_fifo_input_control.sv
// Directed bench for fifo_input_control: reset, fill, overflow, wrap, zero reject
// and read_ack corner cases.
module tb_fifo_input_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_en;
  logic [7:0] data_in;
  logic       read_ack;
  logic       write_en_o;
  logic [4:0] ptr;
  logic [7:0] data_in_f;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       zero_reject;
  logic [5:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_input_control dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_ack    (read_ack),
    .write_en_o  (write_en_o),
    .ptr         (ptr),
    .data_in_f   (data_in_f),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .zero_reject (zero_reject),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  // drive at negedge, sample 1ns after the following posedge
  task automatic step(input logic we, input logic [7:0] d, input logic ra);
    @(negedge clk);
    write_en = we;
    data_in  = d;
    read_ack = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_en = 1'b0; data_in = 8'h00; read_ack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, full, almost_full, overflow, zero_reject, count_o} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_initial: outputs=%h expected 0",
               {write_en_o, ptr, data_in_f, full, almost_full, overflow, zero_reject, count_o});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    n_cmp++;
    if (count_o !== 6'd5) begin
      n_bad++; $display("FAIL reset_prefill_count: got %0d expected 5", count_o);
    end
    // assert reset between edges with a write pending
    #2;
    write_en = 1'b1; data_in = 8'h33;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, full, almost_full, overflow, zero_reject, count_o} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_async: outputs=%h expected 0",
               {write_en_o, ptr, data_in_f, full, almost_full, overflow, zero_reject, count_o});
    end
    @(negedge clk);
    write_en = 1'b0; data_in = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h11, 1'b0);
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, count_o} !== {1'b1, 5'd0, 8'h11, 6'd1}) begin
      n_bad++;
      $display("FAIL reset_first_write: we=%b ptr=%0d data=%h cnt=%0d expected 1/0/11/1",
               write_en_o, ptr, data_in_f, count_o);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(i + 1), 1'b0);
      n_cmp++;
      if (write_en_o !== 1'b1 || ptr !== 5'(i) || data_in_f !== 8'(i + 1)) begin
        n_bad++;
        $display("FAIL fill_write[%0d]: we=%b ptr=%0d data=%h expected 1/%0d/%h",
                 i, write_en_o, ptr, data_in_f, i, i + 1);
      end
      n_cmp++;
      if (count_o !== 6'(i + 1) || almost_full !== (i + 1 >= 28) || full !== (i + 1 == 32)) begin
        n_bad++;
        $display("FAIL fill_flags[%0d]: cnt=%0d af=%b full=%b expected %0d/%b/%b",
                 i, count_o, almost_full, full, i + 1, (i + 1 >= 28), (i + 1 == 32));
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 8'h55, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || write_en_o !== 1'b0 || count_o !== 6'd32 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: ovf=%b we=%b cnt=%0d full=%b expected 1/0/32/1",
               overflow, write_en_o, count_o, full);
    end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (count_o !== 6'd31 || full !== 1'b0 || overflow !== 1'b1 || almost_full !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_read: cnt=%0d full=%b ovf=%b af=%b expected 31/0/1/1",
               count_o, full, overflow, almost_full);
    end
    step(1'b1, 8'h66, 1'b0);
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, overflow, full, count_o} !== {1'b1, 5'd0, 8'h66, 1'b0, 1'b1, 6'd32}) begin
      n_bad++;
      $display("FAIL overflow_wrap: we=%b ptr=%0d data=%h ovf=%b full=%b cnt=%0d expected 1/0/66/0/1/32",
               write_en_o, ptr, data_in_f, overflow, full, count_o);
    end
  endtask

  task automatic test_full_simul();
    step(1'b1, 8'h77, 1'b1);
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, overflow, full, count_o} !== {1'b1, 5'd1, 8'h77, 1'b0, 1'b1, 6'd32}) begin
      n_bad++;
      $display("FAIL full_simul: we=%b ptr=%0d data=%h ovf=%b full=%b cnt=%0d expected 1/1/77/0/1/32",
               write_en_o, ptr, data_in_f, overflow, full, count_o);
    end
    // zero data at full is a zero reject, not an overflow
    step(1'b1, 8'h00, 1'b0);
    n_cmp++;
    if (zero_reject !== 1'b1 || overflow !== 1'b0 || write_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL full_zero: zr=%b ovf=%b we=%b expected 1/0/0", zero_reject, overflow, write_en_o);
    end
  endtask

  task automatic test_zero();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    step(1'b1, 8'h00, 1'b0);
    n_cmp++;
    if ({zero_reject, write_en_o, count_o, ptr, data_in_f} !== {1'b1, 1'b0, 6'd3, 5'd2, 8'hA2}) begin
      n_bad++;
      $display("FAIL zero_reject: zr=%b we=%b cnt=%0d ptr=%0d data=%h expected 1/0/3/2/a2",
               zero_reject, write_en_o, count_o, ptr, data_in_f);
    end
    step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (zero_reject !== 1'b0 || count_o !== 6'd3) begin
      n_bad++;
      $display("FAIL zero_pulse: zr=%b cnt=%0d expected 0/3", zero_reject, count_o);
    end
    step(1'b1, 8'hB0, 1'b0);
    n_cmp++;
    if (ptr !== 5'd3 || count_o !== 6'd4) begin
      n_bad++;
      $display("FAIL zero_next_write: ptr=%0d cnt=%0d expected 3/4", ptr, count_o);
    end
  endtask

  task automatic test_empty_ack();
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (count_o !== 6'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_ack: cnt=%0d full=%b af=%b expected 0/0/0", count_o, full, almost_full);
    end
    step(1'b1, 8'h09, 1'b1);
    n_cmp++;
    if ({write_en_o, ptr, data_in_f, count_o} !== {1'b1, 5'd0, 8'h09, 6'd1}) begin
      n_bad++;
      $display("FAIL empty_simul: we=%b ptr=%0d data=%h cnt=%0d expected 1/0/09/1",
               write_en_o, ptr, data_in_f, count_o);
    end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (count_o !== 6'd0 || write_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_drain: cnt=%0d we=%b expected 0/0", count_o, write_en_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b0);
      n_cmp++;
      if (write_en_o !== 1'b1 || ptr !== 5'(i + 1) || count_o !== 6'(i + 1)) begin
        n_bad++;
        $display("FAIL b2b[%0d]: we=%b ptr=%0d cnt=%0d expected 1/%0d/%0d",
                 i, write_en_o, ptr, count_o, i + 1, i + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b0; write_en = 1'b0; data_in = 8'h00; read_ack = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_simul();
    test_zero();
    test_empty_ack();
    test_back_to_back();
    step(1'b0, 8'h00, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_input_control.md
Name: fifo_input_control

Overview:
Write-side control unit for the 32-entry, 8-bit FIFO. It is the counterpart of the FIFO output control unit. It qualifies producer write requests, generates the registered write strobe, write pointer and write data for the storage array, and tracks occupancy from read acknowledges returned by the output side. It flags overflow, full and almost-full conditions. Data value 0 is reserved as the "empty" encoding across the FIFO, so zero writes are rejected.

Parameters:
DATA_WIDTH, 8, width of data_in / data_in_f
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH = 32
AFULL_THRESH, 28, occupancy at or above which almost_full asserts

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
write_en  input  1  producer write request, sampled each clk
data_in  input  DATA_WIDTH  producer write data
read_ack  input  1  one-cycle pulse from output control: one word consumed
write_en_o  output  1  registered write strobe to storage array
ptr  output  ADDR_WIDTH  registered address of the word written under write_en_o
data_in_f  output  DATA_WIDTH  registered write data to storage array
full  output  1  occupancy == DEPTH
almost_full  output  1  occupancy >= AFULL_THRESH
overflow  output  1  write was refused because FIFO was full; held until next accepted write
zero_reject  output  1  one-cycle pulse: write_en with data_in == 0 was dropped
count_o  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset:
  - reset low clears all state asynchronously.
  - Cleared values: write_en_o=0, ptr=0, data_in_f=0, full=0, almost_full=0, overflow=0, zero_reject=0, count_o=0, internal wr_ptr=0, state=EMPTY.
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-write discards that write.
- FSM states: EMPTY (occ=0), ACTIVE (0<occ<DEPTH), FULL (occ=DEPTH). The state is re-derived each cycle from next occupancy.
- Accept condition, evaluated at the clk edge: write_en && data_in!=0 && (occ<DEPTH || read_ack).
- On accept, the following hold one cycle later:
  - write_en_o=1
  - ptr=wr_ptr (pre-increment)
  - data_in_f=data_in
  - overflow=0
  - wr_ptr increments modulo DEPTH (31 wraps to 0).
- No accept: write_en_o=0. ptr and data_in_f hold their last values.
- Zero data: write_en && data_in==0 gives zero_reject=1 for one cycle. No pointer or occupancy change. Overflow is unchanged. Zero data takes precedence over full, so overflow is not set.
- Full refusal: write_en && data_in!=0 && occ==DEPTH && !read_ack sets overflow=1. Overflow holds until the next accepted write or reset.
- Occupancy update:
  - +1 on accept only.
  - -1 on read_ack only, when occ>0.
  - Unchanged when both occur.
  - read_ack at occ=0 is ignored, with no wrap below 0.
- Simultaneous write and read_ack while FULL: the write is accepted, occupancy stays DEPTH, and overflow stays 0.
- full, almost_full and count_o are registered from next occupancy. They therefore update in the same cycle as write_en_o for the causing write.
- Latency: write_en to write_en_o/ptr/data_in_f is 1 cycle. There are no combinational input-to-output paths.
- Back-to-back writes sustain one accept per cycle.

Test Plan:
1. Assert reset low mid-stream with occ=5 -> all outputs read 0 immediately, without waiting for a clk edge. After release, the first write of 0x11 gives ptr=0.
2. Write 0x01..0x20 on 32 consecutive cycles with no read_ack:
   - write_en_o=1 and ptr=0..31 in order.
   - almost_full rises on the 28th write.
   - full=1 and count_o=32 after the 32nd write.
3. While full, write 0x55 without read_ack -> overflow=1 and write_en_o=0. Then pulse read_ack alone -> count_o=31. Then write 0x66 -> ptr=0 (wrap), overflow=0, full=1.
4. While full, write 0x77 with read_ack in the same cycle -> accepted, count_o stays 32, overflow=0, ptr advances by 1.
5. Write data_in=0x00 with occ=3 -> zero_reject pulses for one cycle, write_en_o=0, count_o=3, ptr unchanged.
6. Pulse read_ack at occ=0 -> count_o stays 0, state EMPTY. Then a simultaneous write of 0x09 and read_ack at occ=0 -> accepted, count_o=1 (the read_ack is ignored).
